// File: rtl/cordic_axil_sched.sv
// Round-robin job scheduler driving a memory-mapped CORDIC core over AXI4-Lite.
// Accepts one angle per job, starts the core, polls status, then returns cos/sin or an error.
module cordic_axil_sched #(
    parameter int ADDR_WIDTH = 4,
    parameter int POLL_MAX   = 16,
    parameter int POLL_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [31:0]           req0_angle,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [31:0]           req1_angle,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [31:0]           rsp_cos,
    output logic [31:0]           rsp_sin,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE, WR_ANGLE, WR_START, POLL_WAIT, RD_STAT, RD_COS, RD_SIN, RESP
    } state_t;

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = $clog2(POLL_GAP + 2);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);
    localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_ANGLE = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_COS   = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] A_SIN   = ADDR_WIDTH'(12);

    state_t        state, state_nx;
    logic          prio, id_q, err_q;
    logic [31:0]   angle_q, cos_q, sin_q;
    logic [PW-1:0] poll_cnt, poll_next;
    logic [GW-1:0] gap_cnt;
    logic          aw_done, w_done, ar_done;
    logic          any_req, grant_id, is_wr, is_rd;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, b_err, r_err, stat_done, rsp_hs;

    // Every channel transfers on the rising edge where VALID && READY; a VALID,
    // once raised, stays high with stable payload until that edge, then drops.
    assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs      = M_AXI_BVALID && M_AXI_BREADY;
    assign ar_hs     = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
    assign b_err     = M_AXI_BRESP != 2'b00;
    assign r_err     = M_AXI_RRESP != 2'b00;
    assign stat_done = M_AXI_RDATA == 32'h0001_0000;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign poll_next = poll_cnt + 1'b1;
    assign any_req   = req0_valid || req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? prio : req1_valid;
    assign is_wr     = (state == WR_ANGLE) || (state == WR_START);
    assign is_rd     = (state == RD_STAT) || (state == RD_COS) || (state == RD_SIN);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (any_req) state_nx = WR_ANGLE;
            WR_ANGLE:  if (b_hs) state_nx = b_err ? RESP : WR_START;
            WR_START:  if (b_hs) state_nx = b_err ? RESP : POLL_WAIT;
            POLL_WAIT: if (gap_cnt == GAP_LAST) state_nx = RD_STAT;
            RD_STAT: begin
                if (r_hs) begin
                    if (r_err)                       state_nx = RESP;
                    else if (stat_done)              state_nx = RD_COS;
                    else if (poll_next == POLL_LAST) state_nx = RESP;
                    else                             state_nx = POLL_WAIT;
                end
            end
            RD_COS:    if (r_hs) state_nx = r_err ? RESP : RD_SIN;
            RD_SIN:    if (r_hs) state_nx = RESP;
            RESP:      if (rsp_hs) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio     <= 1'b0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            angle_q  <= '0;
            cos_q    <= '0;
            sin_q    <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            ar_done  <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                id_q    <= grant_id;
                angle_q <= grant_id ? req1_angle : req0_angle;
                prio    <= ~grant_id;
            end
            // Per-transaction channel flags live only while the FSM stays in one state.
            if (state_nx != state) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                ar_done <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
                if (ar_hs) ar_done <= 1'b1;
            end
            gap_cnt <= (state == POLL_WAIT) ? gap_cnt + 1'b1 : '0;
            if (is_wr && b_hs && b_err) err_q <= 1'b1;
            if (state == RD_STAT && r_hs) begin
                if (r_err) begin
                    err_q <= 1'b1;
                end else if (!stat_done) begin
                    poll_cnt <= poll_next;
                    if (poll_next == POLL_LAST) err_q <= 1'b1;
                end
            end
            if ((state == RD_COS || state == RD_SIN) && r_hs) begin
                if (r_err)                 err_q <= 1'b1;
                else if (state == RD_COS) cos_q <= M_AXI_RDATA;
                else                       sin_q <= M_AXI_RDATA;
            end
            if (state == RESP && rsp_hs) begin
                err_q    <= 1'b0;
                poll_cnt <= '0;
            end
        end
    end

    always_comb begin
        req0_ready    = (state == IDLE) && !reset && any_req && !grant_id;
        req1_ready    = (state == IDLE) && !reset && any_req && grant_id;
        M_AXI_AWVALID = is_wr && !aw_done;
        M_AXI_WVALID  = is_wr && !w_done;
        M_AXI_BREADY  = is_wr;
        M_AXI_AWADDR  = (state == WR_ANGLE) ? A_ANGLE : A_CTRL;
        M_AXI_WDATA   = (state == WR_ANGLE) ? angle_q : 32'h0000_0001;
        M_AXI_WSTRB   = 4'hF;
        M_AXI_ARVALID = is_rd && !ar_done;
        M_AXI_RREADY  = is_rd;
        M_AXI_ARADDR  = A_CTRL;
        if (state == RD_COS) M_AXI_ARADDR = A_COS;
        if (state == RD_SIN) M_AXI_ARADDR = A_SIN;
        rsp_valid     = state == RESP;
        rsp_id        = id_q;
        rsp_err       = err_q;
        rsp_cos       = err_q ? 32'h0 : cos_q;
        rsp_sin       = err_q ? 32'h0 : sin_q;
        dbg_state     = state;
    end
endmodule

// File: tb/tb_cordic_axil_sched.sv
// Directed bench for cordic_axil_sched: behavioural AXI-lite CORDIC slave plus
// write/read/grant scoreboards with expected queues.
module tb_cordic_axil_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_angle, req1_angle;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_cos, rsp_sin;
    logic [3:0]  m_awaddr, m_araddr;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave knobs
    int          aw_delay = 0;
    int          done_after = 1;
    bit          bresp_err_angle = 1'b0;
    logic [31:0] cos_val = '0, sin_val = '0;

    // Scoreboards
    logic [35:0] exp_wr_q[$];
    logic [3:0]  exp_rd_q[$];
    int          grant_q[$];
    bit          sb_en = 1'b1;
    int          overlap_cnt = 0;
    logic [35:0] e_wr;
    logic [3:0]  e_rd;

    // Slave state
    logic        s_aw_got, s_w_got, wr_evt, rd_evt;
    logic [3:0]  s_aw_addr, rd_log;
    logic [31:0] s_w_data;
    logic [35:0] wr_log;
    int          s_aw_cnt, s_ar_cnt, stat_reads, m_aw_stall, m_w_cyc, stall_log, wcyc_log;

    cordic_axil_sched #(.ADDR_WIDTH(4), .POLL_MAX(4), .POLL_GAP(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err),
        .M_AXI_AWADDR(m_awaddr), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
        .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid),
        .M_AXI_WREADY(m_wready), .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid),
        .M_AXI_BREADY(m_bready), .M_AXI_ARADDR(m_araddr), .M_AXI_ARVALID(m_arvalid),
        .M_AXI_ARREADY(m_arready), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp),
        .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // AXI-lite slave: AWREADY after aw_delay stall cycles, WREADY immediate,
    // ARREADY after one stall cycle, B/R one cycle after the address/data phase.
    assign m_awready = m_awvalid && !s_aw_got && (s_aw_cnt >= aw_delay);
    assign m_wready  = m_wvalid && !s_w_got;
    assign m_arready = m_arvalid && !m_rvalid && (s_ar_cnt >= 1);

    always @(posedge clk) begin
        wr_evt <= 1'b0;
        rd_evt <= 1'b0;
        if (reset) begin
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_aw_cnt <= 0; s_ar_cnt <= 0;
            s_aw_addr <= '0; s_w_data <= '0; wr_log <= '0; rd_log <= '0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00; m_rvalid <= 1'b0; m_rresp <= 2'b00;
            m_rdata <= '0; stat_reads <= 0; m_aw_stall <= 0; m_w_cyc <= 0;
            stall_log <= 0; wcyc_log <= 0;
        end else begin
            if (m_awvalid && !m_awready) begin
                s_aw_cnt   <= s_aw_cnt + 1;
                m_aw_stall <= m_aw_stall + 1;
            end
            if (m_awvalid && m_awready) begin
                s_aw_got  <= 1'b1;
                s_aw_addr <= m_awaddr;
                s_aw_cnt  <= 0;
                if (m_awaddr == 4'h4) stat_reads <= 0;
            end
            if (m_wvalid) m_w_cyc <= m_w_cyc + 1;
            if (m_wvalid && m_wready) begin
                s_w_got  <= 1'b1;
                s_w_data <= m_wdata;
            end
            if (s_aw_got && s_w_got && !m_bvalid) begin
                m_bvalid   <= 1'b1;
                m_bresp    <= (bresp_err_angle && s_aw_addr == 4'h4) ? 2'b10 : 2'b00;
                s_aw_got   <= 1'b0;
                s_w_got    <= 1'b0;
                wr_evt     <= 1'b1;
                wr_log     <= {s_aw_addr, s_w_data};
                stall_log  <= m_aw_stall;
                wcyc_log   <= m_w_cyc;
                m_aw_stall <= 0;
                m_w_cyc    <= 0;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_arvalid && !m_arready) s_ar_cnt <= s_ar_cnt + 1;
            if (m_arvalid && m_arready) begin
                s_ar_cnt <= 0;
                m_rvalid <= 1'b1;
                m_rresp  <= 2'b00;
                rd_evt   <= 1'b1;
                rd_log   <= m_araddr;
                case (m_araddr)
                    4'h0: begin
                        m_rdata    <= (stat_reads + 1 >= done_after) ? 32'h0001_0000 : 32'h0;
                        stat_reads <= stat_reads + 1;
                    end
                    4'h8:    m_rdata <= cos_val;
                    4'hC:    m_rdata <= sin_val;
                    default: m_rdata <= 32'hDEAD_BEEF;
                endcase
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    // Scoreboard monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (req0_ready) grant_q.push_back(0);
        if (req1_ready) grant_q.push_back(1);
        if (m_awvalid && m_arvalid) overlap_cnt++;
        if (!reset && sb_en && wr_evt) begin
            if (exp_wr_q.size() == 0) begin
                check("wr_unexpected", {28'h0, wr_log}, 64'h0);
            end else begin
                e_wr = exp_wr_q.pop_front();
                check("wr_addr_data", {28'h0, wr_log}, {28'h0, e_wr});
                check("aw_stall", stall_log, aw_delay);
                check("w_valid_cycles", wcyc_log, 1);
            end
        end
        if (!reset && sb_en && rd_evt) begin
            if (exp_rd_q.size() == 0) begin
                check("rd_unexpected", {60'h0, rd_log}, 64'hF0);
            end else begin
                e_rd = exp_rd_q.pop_front();
                check("rd_addr", {60'h0, rd_log}, {60'h0, e_rd});
            end
        end
    end

    // Driver tasks
    task automatic send_req(input int n, input logic [31:0] angle);
        int k = 0;
        bit got = 1'b0;
        @(posedge clk); #1;
        if (n == 0) begin req0_valid = 1'b1; req0_angle = angle; end
        else        begin req1_valid = 1'b1; req1_angle = angle; end
        while (!got && k < 500) begin
            @(negedge clk);
            got = (n == 0) ? req0_ready : req1_ready;
            k++;
        end
        if (!got) check("req_ready_timeout", 0, 1);
        @(posedge clk); #1;
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic id, input logic err,
                            input logic [31:0] cosv, input logic [31:0] sinv);
        int k = 0;
        while (!rsp_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) begin
            check({tag, "_rsp_timeout"}, 0, 1);
        end else begin
            check({tag, "_id"}, rsp_id, id);
            check({tag, "_err"}, rsp_err, err);
            check({tag, "_cos"}, rsp_cos, cosv);
            check({tag, "_sin"}, rsp_sin, sinv);
            repeat (2) @(negedge clk);
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_data"}, {rsp_id, rsp_err, rsp_cos}, {id, err, cosv});
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic push_job(input logic [31:0] angle, input int polls, input bit reach_results);
        exp_wr_q.push_back({4'h4, angle});
        exp_wr_q.push_back({4'h0, 32'h0000_0001});
        for (int i = 0; i < polls; i++) exp_rd_q.push_back(4'h0);
        if (reach_results) begin
            exp_rd_q.push_back(4'h8);
            exp_rd_q.push_back(4'hC);
        end
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wr_q_left"}, exp_wr_q.size(), 0);
        check({tag, "_rd_q_left"}, exp_rd_q.size(), 0);
    endtask

    int exp_order[4] = '{0, 1, 0, 1};
    int k;

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_angle = '0; req1_angle = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_bready", m_bready, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_rready", m_rready, 0);
        check("rst_req_ready", {req0_ready, req1_ready}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_id, rsp_err, rsp_cos, rsp_sin}, 0);
        check("rst_state", dbg_state, 0);
        check("rst_wstrb", m_wstrb, 4'hF);

        // Nominal job: one not-done poll, then done
        done_after = 2; cos_val = 32'h0000_8004; sin_val = 32'h0000_023F;
        grant_q.delete();
        push_job(32'h4333_0000, 2, 1'b1);
        send_req(0, 32'h4333_0000);
        wait_rsp("nominal", 1'b0, 1'b0, 32'h0000_8004, 32'h0000_023F);
        ack_rsp();
        check_drained("nominal");
        check("nominal_grants", grant_q.size(), 1);
        check("nominal_grant_id", grant_q[0], 0);

        // Skewed write: lone req0 while priority sits with req1
        aw_delay = 3; done_after = 1; cos_val = 32'h0000_1111; sin_val = 32'h0000_2222;
        grant_q.delete();
        push_job(32'h1357_9BDF, 1, 1'b1);
        send_req(0, 32'h1357_9BDF);
        wait_rsp("skew", 1'b0, 1'b0, 32'h0000_1111, 32'h0000_2222);
        ack_rsp();
        check_drained("skew");
        check("skew_grant_id", grant_q[0], 0);
        aw_delay = 0;

        // Timeout: status never done
        done_after = 1000;
        push_job(32'h1234_5678, 4, 1'b0);
        send_req(1, 32'h1234_5678);
        wait_rsp("timeout", 1'b1, 1'b1, 32'h0, 32'h0);
        ack_rsp();
        check_drained("timeout");

        // Bus error on the angle write
        bresp_err_angle = 1'b1; done_after = 1;
        exp_wr_q.push_back({4'h4, 32'hAAAA_5555});
        send_req(0, 32'hAAAA_5555);
        wait_rsp("buserr", 1'b0, 1'b1, 32'h0, 32'h0);
        ack_rsp();
        repeat (3) @(negedge clk);
        check_drained("buserr");
        bresp_err_angle = 1'b0;

        // Error flag cleared for the following job
        push_job(32'h0F0F_0F0F, 1, 1'b1);
        send_req(1, 32'h0F0F_0F0F);
        wait_rsp("recover", 1'b1, 1'b0, 32'h0000_1111, 32'h0000_2222);
        ack_rsp();
        check_drained("recover");

        // Fairness: both requesters held high from reset
        reset = 1'b1;
        req0_valid = 1'b1; req0_angle = 32'h1111_0000;
        req1_valid = 1'b1; req1_angle = 32'h2222_0000;
        repeat (2) @(negedge clk);
        grant_q.delete();
        for (int i = 0; i < 4; i++)
            push_job((exp_order[i] == 0) ? 32'h1111_0000 : 32'h2222_0000, 1, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_rsp("fair", exp_order[i][0], 1'b0, 32'h0000_1111, 32'h0000_2222);
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            ack_rsp();
        end
        repeat (5) @(negedge clk);
        check_drained("fair");
        check("fair_grant_count", grant_q.size(), 4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++)
            check("fair_grant_order", grant_q[i], exp_order[i]);

        // Reset during a status read, then a clean req1 job
        sb_en = 1'b0; done_after = 1000;
        send_req(1, 32'h0BAD_F00D);
        k = 0;
        while (dbg_state != 3'd4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("midpoll_reached_rd_stat", dbg_state, 3'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midpoll_arvalid", m_arvalid, 0);
        check("midpoll_rready", m_rready, 0);
        check("midpoll_state", dbg_state, 0);
        check("midpoll_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_wr_q.delete();
        exp_rd_q.delete();
        sb_en = 1'b1; done_after = 1; cos_val = 32'h0000_7A5C; sin_val = 32'h0000_4B1E;
        push_job(32'h4049_0FDB, 1, 1'b1);
        send_req(1, 32'h4049_0FDB);
        wait_rsp("post_reset", 1'b1, 1'b0, 32'h0000_7A5C, 32'h0000_4B1E);
        ack_rsp();
        check_drained("post_reset");

        check("aw_ar_overlap", overlap_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_axil_sched.md
CORDIC_AXIL_SCHED -- requirements
Module: cordic_axil_sched

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 4, AXI-lite address width; POLL_MAX, 16, status reads before timeout; POLL_GAP, 2, idle cycles between status polls.
REQ-002 SHALL have one clock; reset is synchronous and active-high:
  clk  in  1  clock, all logic on rising edge
  reset  in  1  synchronous active-high reset
REQ-003 SHALL have requester ports, n = 0,1:
  reqn_valid  in  1  job request
  reqn_angle  in  32  angle word, written to the CORDIC angle register
  reqn_ready  out  1  one-cycle accept pulse
REQ-004 SHALL have response ports:
  rsp_valid  out  1  result available
  rsp_ready  in  1  consumer accepts
  rsp_id  out  1  requester index
  rsp_cos, rsp_sin  out  32 each  results
  rsp_err  out  1  bus error or timeout
REQ-005 SHALL have AXI4-Lite master ports (M_AXI_ prefix):
  AWADDR/ARADDR  out  ADDR_WIDTH  addresses
  AWVALID, WVALID, BREADY, ARVALID, RREADY  out  1  master handshakes
  WDATA  out  32  write data
  WSTRB  out  4  always 4'hF
  AWREADY, WREADY, BVALID, ARREADY, RVALID  in  1  slave handshakes
  BRESP, RRESP  in  2  responses
  RDATA  in  32  read data

Function
REQ-006 SHALL use FSM states IDLE, WR_ANGLE, WR_START, POLL_WAIT, RD_STAT, RD_COS, RD_SIN, RESP.
REQ-007 IDLE: when any reqn_valid is high, SHALL choose a requester by round-robin, pulse its reqn_ready for one cycle, latch its angle and id, and enter WR_ANGLE on the next cycle.
REQ-008 Arbitration: after reset, requester 0 SHALL have priority. After each grant, priority SHALL pass to the other requester. A single requester SHALL be granted regardless of priority.
REQ-009 WR_ANGLE SHALL write the latched angle to address 0x4. WR_START SHALL write 32'h1 to address 0x0.
REQ-010 Write protocol: AWVALID and WVALID SHALL assert together. Each SHALL drop on the cycle after its own VALID&&READY, independently of the other. BREADY SHALL be high until BVALID. The FSM SHALL advance only after both handshakes and the B handshake.
REQ-011 A BRESP other than 2'b00 SHALL set the error flag and go directly to RESP.
REQ-012 Read protocol: ARVALID SHALL be held until ARREADY, then dropped. RREADY SHALL be high from ARVALID assertion until RVALID. RDATA SHALL be captured on RVALID&&RREADY. RRESP other than 2'b00 SHALL set the error flag and go to RESP.
REQ-013 After WR_START, the FSM SHALL wait POLL_GAP cycles in POLL_WAIT, then read address 0x0.
REQ-014 Poll results:
  - status == 32'h0001_0000: go to RD_COS.
  - otherwise: increment the poll counter and return to POLL_WAIT.
  - poll counter reaches POLL_MAX without done: set the error flag and go to RESP.
REQ-015 RD_COS SHALL read 0x8 into rsp_cos; RD_SIN SHALL then read 0xC into rsp_sin.
REQ-016 RESP: rsp_valid SHALL be held, with rsp_id/cos/sin/err stable, until rsp_ready. On rsp_valid&&rsp_ready, the FSM SHALL return to IDLE, clear the error flag and poll counter, and allow a new grant no earlier than the next cycle.
REQ-017 On error, rsp_cos and rsp_sin SHALL be 32'h0.
REQ-018 Only one AXI transaction SHALL be outstanding at a time. ARVALID and AWVALID SHALL never be high together.
REQ-019 Requests arriving outside IDLE SHALL wait with reqn_ready low and SHALL NOT be dropped.

Reset
REQ-020 When reset is high at a clock edge, the block SHALL, on that edge:
  - enter IDLE;
  - drive all VALID/READY outputs and reqn_ready low;
  - clear rsp_cos, rsp_sin, rsp_err, rsp_id, the poll counter and the error flag;
  - set priority to requester 0.
  This SHALL apply in any state, including mid-transaction.
REQ-021 The AXI-lite slave SHALL be reset by the same reset; the block SHALL NOT complete an interrupted transaction.

Verification
REQ-022 Nominal job: req0 angle 32'h43330000 -> writes 0x4=43330000, then 0x0=00000001; polls until 10000; reads 0x8, then 0xC; rsp_id=0, rsp_cos=32'h00008004, rsp_sin=32'h0000023F, rsp_err=0.
REQ-023 Fairness: req0 and req1 both held high from reset -> grant order 0,1,0,1, one reqn_ready pulse per job, no lost request.
REQ-024 Skewed write: slave WREADY immediate, AWREADY delayed 3 cycles -> WVALID drops after its handshake; AWVALID held 3 cycles; exactly one write per address.
REQ-025 Timeout: status slave stub always returns 0, POLL_MAX=4 -> exactly 4 reads of 0x0; no reads of 0x8/0xC; rsp_err=1; rsp_cos=rsp_sin=0.
REQ-026 Bus error: BRESP=2'b10 on the angle write -> no write to 0x0; rsp_err=1 on the next RESP.
REQ-027 Reset mid-poll: reset asserted during RD_STAT -> ARVALID/RREADY low on the next edge; after release, a req1 job completes with correct results.
